// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader that writes a program memory and releases the CPU reset.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte to each frame.
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR} state_t;
`endif

  localparam logic [8:0] MAX_LEN = 9'(2 ** ADDR_W);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_idx;
  logic              take;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        acc;
  logic [7:0]        len_q;
`endif

  // Never back-pressured; only held off while reset is asserted.
  assign in_ready = ~rst;
  assign take     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_idx  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc       <= 8'h00;
      len_q     <= 8'h00;
`endif
    end else begin
      mem_we <= 1'b0;
      if (take) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (in_data == SYNC_BYTE) begin
              state     <= ST_LEN;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              cpu_rst_n <= 1'b0;
            end
          end
          ST_LEN: begin
            if (in_data == 8'h00 || {1'b0, in_data} > MAX_LEN) begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end else begin
              // Store L-1 so a full 2**ADDR_W frame still fits the address width.
              last_idx <= ADDR_W'(in_data - 8'd1);
              cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
              acc      <= 8'h00;
              len_q    <= in_data;
`endif
              state    <= ST_DATA;
            end
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt;
            mem_wdata <= in_data;
`ifdef LOADER_CHECKSUM_EN
            acc       <= acc ^ in_data;
`endif
            if (cnt == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= ST_CSUM;
`else
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_rst_n <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CSUM: begin
            // The length byte is folded in here rather than preloaded into acc.
            if (in_data == (acc ^ len_q)) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (ADDR_W=4), with or without LOADER_CHECKSUM_EN.
module tb_prog_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  pl[$];

  prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_write: observed %0h expected none", {4'h0, mem_addr, mem_wdata});
      end else begin
        check("mem_write", {16'h0, 4'h0, mem_addr, mem_wdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_write(input int a, input logic [7:0] d);
    exp_q.push_back({8'(a), d});
  endtask

  // Length, payload and (when enabled) checksum; the sync byte is sent by the caller.
  task automatic send_body(input logic [7:0] len);
    logic [7:0] c;
    c = len;
    send(len);
    for (int i = 0; i < pl.size(); i++) begin
      push_write(i, pl[i]);
      c = c ^ pl[i];
      send(pl[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    send(c);
`endif
  endtask

  task automatic expect_status(input string tag, input logic done, input logic err, input logic crn);
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"}, 32'(load_err), 32'(err));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(crn));
  endtask

  task automatic drained(input string tag);
    idle(1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_we_low"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    expect_status("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready_up", 32'(in_ready), 32'd1);

    // Idle noise, gaps, and a payload byte equal to the sync marker.
    send(8'h00); send(8'h7E);
    expect_status("noise", 1'b0, 1'b0, 1'b0);
    send(8'hA5);
    idle(3);
    send(8'h01);
    idle(2);
    push_write(0, 8'hA5);
    send(8'hA5);
`ifdef LOADER_CHECKSUM_EN
    send(8'hA4);
`else
    check("noise_we_with_done", 32'(mem_we), 32'd1);
`endif
    expect_status("noise_frame", 1'b1, 1'b0, 1'b1);
    send(8'h01);
    expect_status("done_discard", 1'b1, 1'b0, 1'b1);
    drained("noise");
    check("hold_addr", 32'(mem_addr), 32'd0);
    check("hold_wdata", 32'(mem_wdata), 32'hA5);

    // Good three-byte frame, then reload from DONE.
    send(8'hA5);
    pl = {8'h11, 8'h22, 8'h33};
    send_body(8'h03);
    expect_status("good", 1'b1, 1'b0, 1'b1);
    drained("good");
    send(8'hA5);
    expect_status("reload_sync", 1'b0, 1'b0, 1'b0);
    pl = {8'h5A, 8'hC3};
    send_body(8'h02);
    expect_status("reload", 1'b1, 1'b0, 1'b1);
    drained("reload");

    // Bad checksum byte.
    send(8'hA5);
    send(8'h02);
    push_write(0, 8'h10); send(8'h10);
    push_write(1, 8'h20); send(8'h20);
    send(8'hFF);
`ifdef LOADER_CHECKSUM_EN
    expect_status("bad_csum", 1'b0, 1'b1, 1'b0);
`else
    expect_status("bad_csum", 1'b1, 1'b0, 1'b1);
`endif
    drained("bad_csum");

    // Zero and oversize lengths, then the exact maximum length.
    send(8'hA5);
    expect_status("zero_sync", 1'b0, 1'b0, 1'b0);
    send(8'h00);
    expect_status("zero_len", 1'b0, 1'b1, 1'b0);
    send(8'hA5); send(8'h11);
    expect_status("over_len", 1'b0, 1'b1, 1'b0);
    drained("over_len");
    send(8'hA5);
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(i * 7 + 3));
    send_body(8'h10);
    expect_status("max_len", 1'b1, 1'b0, 1'b1);
    drained("max_len");
    check("max_last_addr", 32'(mem_addr), 32'd15);

    // Reset mid-frame abandons the frame.
    send(8'hA5); send(8'h04);
    push_write(0, 8'h01); send(8'h01);
    push_write(1, 8'h02); send(8'h02);
    idle(1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    expect_status("mid_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'hA5);
    pl = {8'h09};
    send_body(8'h01);
    expect_status("post_rst", 1'b1, 1'b0, 1'b1);
    drained("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width (1..8).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  incoming byte stream.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-008 mem_we  output  1  program-memory write strobe, one cycle per data byte.
REQ-009 mem_addr  output  ADDR_W  program-memory write address.
REQ-010 mem_wdata  output  8  program-memory write data.
REQ-011 cpu_rst_n  output  1  processor reset, active-low; low while no valid program is loaded.
REQ-012 load_done  output  1  level; last frame loaded successfully.
REQ-013 load_err  output  1  level; last frame rejected.

Function
REQ-014 Frame = SYNC_BYTE, LEN, LEN data bytes, then CSUM byte when LOADER_CHECKSUM_EN is defined.
REQ-015 States SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 in_ready SHALL be 1 in every state; transfers are never back-pressured.
REQ-017 IDLE/DONE/ERR: accepted SYNC_BYTE -> LEN; any other accepted byte is discarded, state unchanged.
REQ-018 Leaving DONE or ERR on SYNC_BYTE SHALL clear load_done, load_err and drive cpu_rst_n low the next cycle.
REQ-019 LEN: accepted byte L; L==0 or L > 2**ADDR_W -> ERR; else store L, clear address counter and checksum accumulator to 0, -> DATA.
REQ-020 DATA: byte k (k=0..L-1) accepted at cycle t -> mem_we=1, mem_addr=k, mem_wdata=byte in cycle t+1 only (one-cycle registered latency).
REQ-021 mem_we SHALL be 0 in every cycle not following an accepted data byte; mem_addr/mem_wdata hold last values.
REQ-022 After byte L-1: -> CSUM if LOADER_CHECKSUM_EN, else -> DONE.
REQ-023 Checksum = 8-bit XOR of L and all L data bytes.
REQ-024 CSUM: accepted byte equal to checksum -> DONE; otherwise -> ERR.
REQ-025 Entering DONE: load_done=1, cpu_rst_n=1 in the cycle after the final accepted byte, concurrent with the final mem_we when no checksum.
REQ-026 Entering ERR: load_err=1, cpu_rst_n stays 0; already-written memory is not rolled back.
REQ-027 SYNC_BYTE value inside LEN/DATA/CSUM SHALL be treated as ordinary payload, never as restart.
REQ-028 Cycles with in_valid=0 SHALL not advance state, counters or accumulator; gaps of any length allowed.
REQ-029 Address counter SHALL not wrap: L=2**ADDR_W writes addresses 0..2**ADDR_W-1 exactly once.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0, counters and accumulator 0.
REQ-031 rst asserted mid-frame SHALL abandon the frame; first post-reset byte is processed from IDLE.
REQ-032 in_ready SHALL be 0 while rst=1.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: CSUM state, accumulator and checksum compare present; frame ends with CSUM byte.
REQ-034 Macro undefined: no CSUM state or accumulator logic; frame ends after last data byte; checksum mismatch error cannot occur.

Verification
REQ-035 Good frame, checksum on: A5,03,11,22,33,03 (03^11^22^33=03) -> writes (0,11),(1,22),(2,33) on consecutive cycles; load_done=1, cpu_rst_n=1 one cycle after CSUM.
REQ-036 Bad checksum: A5,02,10,20,FF -> two writes (0,10),(1,20); load_err=1, cpu_rst_n=0, load_done=0.
REQ-037 Idle noise and gaps: 00,7E,A5, 3-cycle gap, 01, 2-cycle gap, A5, 01 -> single write (0,A5); in-payload A5 not a restart; DONE.
REQ-038 Zero/oversize length: A5,00 -> ERR; with ADDR_W=4, A5,11 -> ERR; no mem_we in either.
REQ-039 Reset mid-frame: A5,04,01,02 then rst pulse -> all outputs at reset values; following A5,01,09,(csum 08) -> write (0,09), DONE.
REQ-040 Reload from DONE: after REQ-035 frame send A5 -> load_done=0, cpu_rst_n=0 next cycle; complete second frame -> DONE again.
